// File: rtl/alu_operand_loader.sv
// -----------------------------------------------------------------------------
// alu_operand_loader
//
// Front end for the 8-bit combinational ALU. Three raw push-buttons are each
// synchronized (2 flops), optionally debounced and rising-edge detected. A
// detected press latches the shared switch bank into the A operand, the
// B operand or the opcode register. A four-state sequencer tracks entry order
// and raises `ready` once A, B and OP have been entered in that order.
//
// Build option:
//   LOADER_DEBOUNCE_EN  defined   -> per-button debounce counters present.
//                                    A level change needs DEBOUNCE_CYCLES
//                                    consecutive stable synchronized samples.
//                       undefined -> no counters. The debounced level is the
//                                    synchronized level, so every synchronized
//                                    rise (bounce included) is a press.
//
// Parameters:
//   WIDTH            width of sw and of the a/b/op registers
//   DEBOUNCE_CYCLES  stable cycles needed to accept a level change (>= 2)
//
// Ports:
//   clk      in   system clock, all state updates on the rising edge
//   reset    in   asynchronous active-high reset
//   sw       in   switch bank, sampled only on the loading edge
//   btn_a    in   raw button, load A operand
//   btn_b    in   raw button, load B operand
//   btn_op   in   raw button, load opcode
//   a        out  registered A operand
//   b        out  registered B operand
//   op       out  registered opcode
//   ready    out  high while the sequencer is in READY
//   state    out  sequencer state: WAIT_A=0, WAIT_B=1, WAIT_OP=2, READY=3
// -----------------------------------------------------------------------------
module alu_operand_loader #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_a,
    input  logic             btn_b,
    input  logic             btn_op,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] op,
    output logic             ready,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        READY   = 2'd3
    } state_t;

    // Bit positions of the three buttons inside the packed button vectors.
    localparam int BTN_A   = 0;
    localparam int BTN_B   = 1;
    localparam int BTN_OP  = 2;
    localparam int NUM_BTN = 3;

    // A counter that must reach DEBOUNCE_CYCLES-1 needs at least two states.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cycles
        $error("alu_operand_loader: DEBOUNCE_CYCLES must be at least 2");
    end

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press;

    assign btn_raw[BTN_A]  = btn_a;
    assign btn_raw[BTN_B]  = btn_b;
    assign btn_raw[BTN_OP] = btn_op;

    // -------------------------------------------------------------------------
    // Button conditioning: synchronizer -> debounce -> rising-edge pulse
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        logic sync1_q;      // first synchronizer stage (may go metastable)
        logic s_q;          // synchronized level
        logic db;           // debounced level
        logic db_prev_q;    // debounced level one cycle earlier

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync1_q <= 1'b0;
                s_q     <= 1'b0;
            end else begin
                sync1_q <= btn_raw[gi];
                s_q     <= sync1_q;
            end
        end

`ifdef LOADER_DEBOUNCE_EN
        localparam int CW = $clog2(DEBOUNCE_CYCLES);
        localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

        logic          db_q;
        logic          db_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        // The count only advances while the synchronized level disagrees with
        // the accepted level; any agreeing sample (a glitch ending) restarts
        // it, so a pulse shorter than DEBOUNCE_CYCLES never flips db.
        always_comb begin
            cnt_d = cnt_q;
            db_d  = db_q;
            if (s_q == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                db_d  = s_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                db_q  <= 1'b0;
                cnt_q <= '0;
            end else begin
                db_q  <= db_d;
                cnt_q <= cnt_d;
            end
        end

        assign db = db_q;
`else
        // Source is trusted to be clean (or this is a fast simulation build).
        assign db = s_q;
`endif

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                db_prev_q <= 1'b0;
            end else begin
                db_prev_q <= db;
            end
        end

        // One pulse per debounced rising edge; releases are silent. Because
        // db_prev_q clears on reset, a button held through reset counts as a
        // fresh press once its level is re-accepted.
        assign press[gi] = db & ~db_prev_q;
    end

    // -------------------------------------------------------------------------
    // Entry sequencer and load enables
    // -------------------------------------------------------------------------
    state_t state_q;
    state_t state_d;
    logic   ready_q;
    logic   load_a;
    logic   load_b;
    logic   load_op;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] op_q;

    always_comb begin
        state_d = state_q;
        load_a  = 1'b0;
        load_b  = 1'b0;
        load_op = 1'b0;

        case (state_q)
            WAIT_A: begin
                // Only A is accepted before any operand exists.
                if (press[BTN_A]) begin
                    load_a  = 1'b1;
                    state_d = WAIT_B;
                end
            end

            WAIT_B: begin
                // A re-entry takes priority: it is a correction of the
                // previous step, so the order restarts from B.
                if (press[BTN_A]) begin
                    load_a = 1'b1;
                end else if (press[BTN_B]) begin
                    load_b  = 1'b1;
                    state_d = WAIT_OP;
                end
            end

            WAIT_OP: begin
                // A re-entry invalidates the B->OP progress and wins over a
                // coincident OP press, which is then dropped.
                if (press[BTN_A]) begin
                    load_a  = 1'b1;
                    state_d = WAIT_B;
                end else begin
                    if (press[BTN_B]) begin
                        load_b = 1'b1;
                    end
                    if (press[BTN_OP]) begin
                        load_op = 1'b1;
                        state_d = READY;
                    end
                end
            end

            READY: begin
                // Everything is valid; each press simply edits its register.
                load_a  = press[BTN_A];
                load_b  = press[BTN_B];
                load_op = press[BTN_OP];
            end

            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_A;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Registered decode keeps ready aligned with the state register
            // and free of combinational glitches.
            ready_q <= (state_d == READY);
        end
    end

    // Operand/opcode registers only change on their own load enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else begin
            if (load_a) begin
                a_q <= sw;
            end
            if (load_b) begin
                b_q <= sw;
            end
            if (load_op) begin
                op_q <= sw;
            end
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign op    = op_q;
    assign ready = ready_q;
    assign state = state_q;

endmodule
